fixed_point_descaler: RTL and testbench

FIXED_POINT_DESCALER -- requirements
Module: fixed_point_descaler

---
 rtl/fixed_point_descaler_if.sv | 30 +++
 rtl/fixed_point_descaler.sv | 145 ++++++++++++++
 tb/tb_fixed_point_descaler.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_descaler_if.sv
// rtl/fixed_point_descaler_if.sv - operand/result handshake bundle for fixed_point_descaler
// The master drives operands and out_ready; the slave (the descaler) returns results.
interface fixed_point_descaler_if #(
  parameter int BB = 16,
  parameter int BC = 27,
  parameter int BP = 45,
  parameter int BQ = 27
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [BP-1:0] p;
  logic        [BB-1:0] b;
  logic signed [BC-1:0] c;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [BQ-1:0] q;
  logic signed [BB:0]   r;
  logic                 sat;
  logic                 dz;

  modport master (
    output in_valid, p, b, c, out_ready,
    input  in_ready, out_valid, q, r, sat, dz
  );

  modport slave (
    input  in_valid, p, b, c, out_ready,
    output in_ready, out_valid, q, r, sat, dz
  );
endinterface

// File: rtl/fixed_point_descaler.sv
// rtl/fixed_point_descaler.sv - sequential descaler q = (p - c) / b via sign-magnitude restoring division
// Optional macro FIXED_POINT_DESCALER_ROUND_EN: round half away from zero instead of truncating.
module fixed_point_descaler #(
  parameter int BB = 16,
  parameter int BC = 27,
  parameter int BP = 45,
  parameter int BQ = 27
) (
  input logic                   clk,
  input logic                   clr,
  fixed_point_descaler_if.slave bus
);
  localparam int BD = BP + 1;
  localparam int CW = $clog2(BD);
  localparam logic [CW-1:0] CNT_LAST = CW'(BD - 1);
  localparam logic signed [BQ-1:0] QMAX = {1'b0, {(BQ-1){1'b1}}};
  localparam logic signed [BQ-1:0] QMIN = {1'b1, {(BQ-1){1'b0}}};
  localparam logic [BD:0] LIM_POS = {{(BD+2-BQ){1'b0}}, {(BQ-1){1'b1}}};
  localparam logic [BD:0] LIM_NEG = {{(BD+1-BQ){1'b0}}, 1'b1, {(BQ-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_FIX, S_DONE} state_t;

  state_t               r_state;
  logic signed [BP-1:0] r_p;
  logic        [BB-1:0] r_b;
  logic signed [BC-1:0] r_c;
  logic                 r_neg;
  logic        [BD-1:0] r_quo;
  logic        [BB:0]   r_rem;
  logic        [CW-1:0] r_cnt;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic signed [BQ-1:0] r_q;
  logic signed [BB:0]   r_r;
  logic                 r_sat;
  logic                 r_dz;

  logic signed [BD-1:0] w_diff;
  logic        [BD-1:0] w_mag;
  logic        [BB:0]   w_trial;
  logic                 w_ge;
  logic        [BB:0]   w_rem_next;
  logic        [BD:0]   w_qmag;
  logic        [BD:0]   w_lim;
  logic                 w_sat;
  logic signed [BQ-1:0] w_q;
  logic signed [BB:0]   w_r;

  // Both operands sign-extended to BP+1 bits so the difference cannot overflow.
  assign w_diff = {r_p[BP-1], r_p} - {{(BD-BC){r_c[BC-1]}}, r_c};
  assign w_mag  = w_diff[BD-1] ? -w_diff : w_diff;

  // r_quo doubles as dividend shifter (MSB out) and quotient collector (LSB in).
  assign w_trial    = {r_rem[BB-1:0], r_quo[BD-1]};
  assign w_ge       = w_trial >= {1'b0, r_b};
  assign w_rem_next = w_ge ? w_trial - {1'b0, r_b} : w_trial;

`ifdef FIXED_POINT_DESCALER_ROUND_EN
  logic w_round;
  assign w_round = {r_rem, 1'b0} >= {2'b00, r_b};
  assign w_qmag  = {1'b0, r_quo} + {{BD{1'b0}}, w_round};
`else
  assign w_qmag  = {1'b0, r_quo};
`endif

  assign w_lim = r_neg ? LIM_NEG : LIM_POS;
  assign w_sat = w_qmag > w_lim;
  assign w_q   = w_sat ? (r_neg ? QMIN : QMAX)
                       : (r_neg ? -$signed(w_qmag[BQ-1:0]) : $signed(w_qmag[BQ-1:0]));
  assign w_r   = r_neg ? -$signed(r_rem) : $signed(r_rem);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_p         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_neg       <= 1'b0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
      r_sat       <= 1'b0;
      r_dz        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_p        <= bus.p;
            r_b        <= bus.b;
            r_c        <= bus.c;
            r_in_ready <= 1'b0;
            r_state    <= S_PREP;
          end
        end
        S_PREP: begin
          r_neg   <= w_diff[BD-1];
          r_quo   <= w_mag;
          r_rem   <= '0;
          r_cnt   <= '0;
          r_state <= (r_b == '0) ? S_FIX : S_DIV;
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[BD-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_b == '0) begin
            r_q   <= r_neg ? QMIN : QMAX;
            r_r   <= '0;
            r_sat <= 1'b1;
            r_dz  <= 1'b1;
          end else begin
            r_q   <= w_q;
            r_r   <= w_r;
            r_sat <= w_sat;
            r_dz  <= 1'b0;
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.q         = r_q;
  assign bus.r         = r_r;
  assign bus.sat       = r_sat;
  assign bus.dz        = r_dz;
endmodule

// File: tb/tb_fixed_point_descaler.sv
// tb/tb_fixed_point_descaler.sv - randomized self-checking bench for fixed_point_descaler
// Reference results come from plain integer arithmetic on (p - c) / b.
module tb_fixed_point_descaler;
  localparam int BB = 16;
  localparam int BC = 27;
  localparam int BP = 45;
  localparam int BQ = 27;
  localparam longint QMAX = (longint'(1) <<< (BQ - 1)) - 1;
  localparam longint QMIN = -(longint'(1) <<< (BQ - 1));
  localparam int LAT = 48;

  logic clk = 1'b0;
  logic clr;
  int   errors = 0;
  int   checks = 0;

  fixed_point_descaler_if #(.BB(BB), .BC(BC), .BP(BP), .BQ(BQ)) bus ();

  fixed_point_descaler #(.BB(BB), .BC(BC), .BP(BP), .BQ(BQ)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  longint exp_q, exp_r;
  bit     exp_sat, exp_dz;
  bit     obs_to;
  int     obs_lat, obs_hold_bad;
  longint obs_q0, obs_r0, obs_q1, obs_r1;
  bit     obs_sat0, obs_dz0, obs_sat1, obs_dz1, obs_post_valid, obs_post_ready;

  function automatic void model(input longint pv, input longint bv, input longint cv);
    longint diff, qt, rt, ar;
    diff = pv - cv;
    if (bv == 0) begin
      exp_dz = 1'b1; exp_sat = 1'b1; exp_r = 0;
      exp_q  = (diff >= 0) ? QMAX : QMIN;
    end else begin
      qt = diff / bv;
      rt = diff % bv;
      ar = (rt < 0) ? -rt : rt;
`ifdef FIXED_POINT_DESCALER_ROUND_EN
      if (2 * ar >= bv) qt = (diff < 0) ? qt - 1 : qt + 1;
`endif
      exp_dz  = 1'b0;
      exp_r   = rt;
      exp_sat = (qt > QMAX) || (qt < QMIN);
      exp_q   = (qt > QMAX) ? QMAX : ((qt < QMIN) ? QMIN : qt);
    end
  endfunction

  task automatic scramble_inputs();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    bus.p = t[BP-1:0];
    bus.b = t[BB+7:8];
    bus.c = t[BC+20:21];
  endtask

  // Drives one operation from a negedge and records what the DUT showed; ends on a negedge.
  task automatic run_op(input longint pv, input longint bv, input longint cv,
                        input int hold, input bit noise);
    int k;
    obs_to = 1'b0; obs_lat = -1; obs_hold_bad = 0;
    bus.p = pv[BP-1:0];
    bus.b = bv[BB-1:0];
    bus.c = cv[BC-1:0];
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      obs_to = 1'b1;
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = noise;
    k = 0;
    while (!bus.out_valid && k < 200) begin
      if (bus.in_ready) obs_hold_bad++;
      if (noise) scramble_inputs();
      @(negedge clk);
      k++;
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) begin
      obs_to = 1'b1;
      return;
    end
    obs_lat = k;
    obs_q0 = longint'(bus.q); obs_r0 = longint'(bus.r);
    obs_sat0 = bus.sat; obs_dz0 = bus.dz;
    if (bus.in_ready) obs_hold_bad++;
    repeat (hold) begin
      @(negedge clk);
      if (bus.in_ready || !bus.out_valid) obs_hold_bad++;
    end
    obs_q1 = longint'(bus.q); obs_r1 = longint'(bus.r);
    obs_sat1 = bus.sat; obs_dz1 = bus.dz;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    obs_post_valid = bus.out_valid;
    obs_post_ready = bus.in_ready;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.p = 45'd77; bus.b = 16'd3; bus.c = 27'd0;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.q !== '0 || bus.r !== '0) begin errors++; $display("FAIL reset_qr got q=%0d r=%0d want 0 0", bus.q, bus.r); end
    checks++; if (bus.sat !== 1'b0 || bus.dz !== 1'b0) begin errors++; $display("FAIL reset_flags got sat=%b dz=%b want 0 0", bus.sat, bus.dz); end
    bus.in_valid = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_directed();
    longint dp [2] = '{300, -107};
    longint db [2] = '{16, 10};
    longint dc [2] = '{-20, 0};
    for (int i = 0; i < 2; i++) begin
      model(dp[i], db[i], dc[i]);
      run_op(dp[i], db[i], dc[i], 0, 1'b0);
      checks++;
      if (obs_to) begin errors++; $display("FAIL directed%0d timeout got=1 want=0", i); continue; end
      checks++; if (obs_lat !== LAT) begin errors++; $display("FAIL directed%0d latency got=%0d want=%0d", i, obs_lat, LAT); end
      checks++; if (obs_q0 !== exp_q) begin errors++; $display("FAIL directed%0d q got=%0d want=%0d", i, obs_q0, exp_q); end
      checks++; if (obs_r0 !== exp_r) begin errors++; $display("FAIL directed%0d r got=%0d want=%0d", i, obs_r0, exp_r); end
      checks++; if (obs_sat0 !== exp_sat || obs_dz0 !== exp_dz) begin errors++; $display("FAIL directed%0d flags got sat=%b dz=%b want %b %b", i, obs_sat0, obs_dz0, exp_sat, exp_dz); end
    end
  endtask

  task automatic test_div_by_zero();
    longint dp [2] = '{5, -5};
    for (int i = 0; i < 2; i++) begin
      model(dp[i], 0, 0);
      run_op(dp[i], 0, 0, 0, 1'b0);
      checks++;
      if (obs_to) begin errors++; $display("FAIL dz%0d timeout got=1 want=0", i); continue; end
      checks++; if (obs_q0 !== exp_q) begin errors++; $display("FAIL dz%0d q got=%0d want=%0d", i, obs_q0, exp_q); end
      checks++; if (obs_r0 !== 0) begin errors++; $display("FAIL dz%0d r got=%0d want=0", i, obs_r0); end
      checks++; if (obs_sat0 !== 1'b1 || obs_dz0 !== 1'b1) begin errors++; $display("FAIL dz%0d flags got sat=%b dz=%b want 1 1", i, obs_sat0, obs_dz0); end
    end
  endtask

  task automatic test_saturation();
    longint dp [3] = '{longint'(1) <<< 40, -(longint'(1) <<< 40), 67108864};
    longint db [3] = '{1, 1, 1};
    for (int i = 0; i < 3; i++) begin
      model(dp[i], db[i], 0);
      run_op(dp[i], db[i], 0, 0, 1'b0);
      checks++;
      if (obs_to) begin errors++; $display("FAIL sat%0d timeout got=1 want=0", i); continue; end
      checks++; if (obs_q0 !== exp_q) begin errors++; $display("FAIL sat%0d q got=%0d want=%0d", i, obs_q0, exp_q); end
      checks++; if (obs_sat0 !== exp_sat || obs_dz0 !== 1'b0) begin errors++; $display("FAIL sat%0d flags got sat=%b dz=%b want %b 0", i, obs_sat0, obs_dz0, exp_sat); end
    end
  endtask

  task automatic test_back_to_back();
    longint dp [2] = '{-123457, 99999};
    longint db [2] = '{11, 13};
    longint dc [2] = '{1000, -3};
    for (int i = 0; i < 2; i++) begin
      model(dp[i], db[i], dc[i]);
      run_op(dp[i], db[i], dc[i], (i == 0) ? 10 : 0, 1'b0);
      checks++;
      if (obs_to) begin errors++; $display("FAIL b2b%0d timeout got=1 want=0", i); continue; end
      checks++; if (obs_hold_bad !== 0) begin errors++; $display("FAIL b2b%0d busy_ready_or_drop got=%0d want=0", i, obs_hold_bad); end
      checks++; if (obs_q1 !== exp_q || obs_r1 !== exp_r) begin errors++; $display("FAIL b2b%0d held_qr got q=%0d r=%0d want %0d %0d", i, obs_q1, obs_r1, exp_q, exp_r); end
      checks++; if (obs_sat1 !== exp_sat || obs_dz1 !== exp_dz) begin errors++; $display("FAIL b2b%0d held_flags got sat=%b dz=%b want %b %b", i, obs_sat1, obs_dz1, exp_sat, exp_dz); end
      checks++; if (obs_post_valid !== 1'b0 || obs_post_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d after_accept got valid=%b ready=%b want 0 1", i, obs_post_valid, obs_post_ready); end
    end
  endtask

  task automatic test_clr_abort();
    int k;
    int seen;
    bus.p = 45'd123456; bus.b = 16'd3; bus.c = 27'd0;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    // Cycle after the handshake is PREP; the 10th DIV cycle starts 10 edges later.
    repeat (10) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr_abort_state got ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid); end
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL clr_abort_no_output got=%0d want=0", seen); end
    model(1000, 7, 0);
    run_op(1000, 7, 0, 0, 1'b0);
    checks++;
    if (obs_to) begin errors++; $display("FAIL clr_next timeout got=1 want=0"); return; end
    checks++; if (obs_lat !== LAT) begin errors++; $display("FAIL clr_next latency got=%0d want=%0d", obs_lat, LAT); end
    checks++; if (obs_q0 !== exp_q || obs_r0 !== exp_r) begin errors++; $display("FAIL clr_next qr got q=%0d r=%0d want %0d %0d", obs_q0, obs_r0, exp_q, exp_r); end
  endtask

  task automatic test_random();
    logic [63:0] t;
    logic signed [BP-1:0] ps;
    logic signed [BC-1:0] cs;
    longint pv, bv, cv;
    int mode;
    for (int i = 0; i < 24; i++) begin
      t = {$urandom(), $urandom()};
      mode = $urandom_range(0, 3);
      ps = t[BP-1:0];
      cs = t[BC+30:31];
      if (mode == 0) begin
        pv = longint'($urandom_range(0, 200000)) - 100000;
        cv = longint'($urandom_range(0, 2000)) - 1000;
      end else begin
        pv = ps;
        cv = cs;
      end
      case ($urandom_range(0, 3))
        0:       bv = longint'($urandom_range(1, 20));
        1:       bv = 0;
        default: bv = longint'($urandom_range(1, 65535));
      endcase
      model(pv, bv, cv);
      run_op(pv, bv, cv, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      checks++;
      if (obs_to) begin errors++; $display("FAIL rand%0d timeout got=1 want=0", i); continue; end
      checks++; if (obs_q0 !== exp_q || obs_r0 !== exp_r) begin errors++; $display("FAIL rand%0d qr p=%0d b=%0d c=%0d got q=%0d r=%0d want %0d %0d", i, pv, bv, cv, obs_q0, obs_r0, exp_q, exp_r); end
      checks++; if (obs_sat1 !== exp_sat || obs_dz1 !== exp_dz) begin errors++; $display("FAIL rand%0d flags got sat=%b dz=%b want %b %b", i, obs_sat1, obs_dz1, exp_sat, exp_dz); end
      checks++; if (obs_hold_bad !== 0) begin errors++; $display("FAIL rand%0d busy_ready got=%0d want=0", i, obs_hold_bad); end
      if (bv != 0) begin
        checks++; if (obs_lat !== LAT) begin errors++; $display("FAIL rand%0d latency got=%0d want=%0d", i, obs_lat, LAT); end
      end
    end
  endtask

  initial begin
    clr = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.p = '0; bus.b = '0; bus.c = '0;
    test_reset();
    test_directed();
    test_div_by_zero();
    test_saturation();
    test_back_to_back();
    test_clr_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
